// File: rtl/led_serial_feeder.sv
// rtl/led_serial_feeder.sv - serialises 16-bit gray-level words LSB-first on dai/den with idle gaps and frame counting
module led_serial_feeder #(
    parameter int GAP_CYCLES      = 2,
    parameter int WORDS_PER_FRAME = 256
) (
    input  logic        dck,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        dai,
    output logic        den,
    output logic [7:0]  word_cnt,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] WORD_LAST = 8'(WORDS_PER_FRAME - 1);

    state_t      state, state_next;
    logic [15:0] hold;
    logic        hold_valid;
    logic [15:0] shreg;
    logic [4:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic        load;
    logic        word_end;

    assign pix_ready = ~hold_valid;

    always_ff @(posedge dck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        word_end   = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid && en) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // bit_cnt reaches 16 one edge after bit 15 was driven
                if (bit_cnt == 5'd16) begin
                    word_end   = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (hold_valid && en) begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge dck or posedge rst) begin
        if (rst) begin
            hold       <= 16'd0;
            hold_valid <= 1'b0;
            shreg      <= 16'd0;
            bit_cnt    <= 5'd0;
            gap_cnt    <= 4'd0;
            dai        <= 1'b0;
            den        <= 1'b0;
            word_cnt   <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Capture needs an empty hold and load needs a full one, so they never collide
            if (pix_valid && !hold_valid) begin
                hold       <= pix_data;
                hold_valid <= 1'b1;
            end
            if (load) begin
                shreg      <= hold;
                hold_valid <= 1'b0;
                den        <= 1'b1;
                dai        <= hold[0];
                bit_cnt    <= 5'd1;
            end else if (state == SHIFT) begin
                if (word_end) begin
                    den     <= 1'b0;
                    dai     <= 1'b0;
                    gap_cnt <= 4'd0;
                    if (word_cnt == WORD_LAST) begin
                        word_cnt   <= 8'd0;
                        frame_done <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 8'd1;
                    end
                end else begin
                    dai     <= shreg[bit_cnt[3:0]];
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_serial_feeder.sv
// tb/tb_led_serial_feeder.sv - scoreboard bench for led_serial_feeder
module tb_led_serial_feeder;

    logic        dck;
    logic        rst;
    logic        en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        dai;
    logic        den;
    logic [7:0]  word_cnt;
    logic        frame_done;

    int checks      = 0;
    int failures    = 0;
    int words_done  = 0;
    int fd_count    = 0;
    int model_cnt   = 0;
    int cyc         = 0;
    int last_rise   = 0;
    bit rise_ok     = 0;
    bit stream_mode = 0;
    bit prev_den    = 0;
    int hi          = 0;
    logic [15:0] shw;
    logic [15:0] exp_q[$];

    led_serial_feeder #(.GAP_CYCLES(2), .WORDS_PER_FRAME(256)) dut (
        .dck(dck), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .dai(dai), .den(den), .word_cnt(word_cnt),
        .frame_done(frame_done)
    );

    initial dck = 1'b0;
    always #5 dck = ~dck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: rebuilds each serial word and compares against the scoreboard queue
    always @(negedge dck) begin
        logic [15:0] e;
        bit wrap;
        cyc++;
        if (rst) begin
            prev_den  = 0;
            hi        = 0;
            shw       = 16'd0;
            model_cnt = 0;
            rise_ok   = 0;
        end else begin
            if (frame_done) fd_count++;
            if (den) begin
                if (!prev_den) begin
                    if (stream_mode && rise_ok) chk("den_period", cyc - last_rise, 18);
                    last_rise = cyc;
                    rise_ok   = 1;
                end
                if (hi < 16) shw[hi] = dai;
                hi++;
            end else begin
                if (dai !== 1'b0) chk("dai_idle", dai, 0);
                if (prev_den) begin
                    chk("den_len", hi, 16);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", shw, 16'hxxxx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", shw, e);
                    end
                    words_done++;
                    wrap      = (model_cnt == 255);
                    model_cnt = wrap ? 0 : model_cnt + 1;
                    chk("frame_done", frame_done, wrap);
                    chk("word_cnt", word_cnt, model_cnt);
                    hi = 0;
                end
            end
            prev_den = den;
        end
    end

    task automatic send_word(input logic [15:0] d);
        int n = 0;
        pix_data  = d;
        pix_valid = 1'b1;
        while (!pix_ready && n < 200) begin
            @(negedge dck);
            n++;
        end
        if (!pix_ready) begin
            chk("send_timeout", 0, 1);
            pix_valid = 1'b0;
        end else begin
            @(posedge dck);
            exp_q.push_back(d);
            @(negedge dck);
            pix_valid = 1'b0;
        end
    endtask

    task automatic wait_words(input int target);
        int n = 0;
        while (words_done < target && n < 6000) begin
            @(negedge dck);
            n++;
        end
        chk("wait_words", words_done >= target, 1);
    endtask

    task automatic do_reset();
        @(negedge dck);
        rst = 1'b1;
        repeat (2) @(negedge dck);
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        en        = 1'b1;
        pix_valid = 1'b0;
        pix_data  = 16'd0;
        repeat (3) @(negedge dck);
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_den", den, 0);
        chk("rst_dai", dai, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        @(negedge dck);

        // Single word with latency check
        send_word(16'hA5C3);
        chk("lat_edge1_den", den, 0);
        @(negedge dck);
        chk("lat_edge2_den", den, 1);
        chk("lat_first_bit", dai, 1);
        wait_words(1);
        repeat (2) @(negedge dck);
        chk("t1_word_cnt", word_cnt, 1);
        chk("t1_den_low", den, 0);

        // Full frame streamed back-to-back
        do_reset();
        words_done  = 0;
        fd_count    = 0;
        stream_mode = 1;
        for (int i = 0; i < 256; i++) send_word(16'(i * 257) ^ 16'h5A3C);
        wait_words(256);
        stream_mode = 0;
        repeat (3) @(negedge dck);
        chk("t2_frame_pulses", fd_count, 1);
        chk("t2_word_cnt", word_cnt, 0);

        // Upstream stall drops the FSM back to idle
        for (int i = 0; i < 3; i++) send_word(16'h1234 + 16'(i));
        repeat (40) @(negedge dck);
        chk("t3_idle_den", den, 0);
        chk("t3_idle_dai", dai, 0);
        chk("t3_done", words_done, 259);
        send_word(16'hFFFF);
        chk("t3_lat1", den, 0);
        @(negedge dck);
        chk("t3_lat2", den, 1);
        wait_words(260);

        // en dropped mid-word: current word finishes, waiting word held
        repeat (5) @(negedge dck);
        send_word(16'h0F0F);
        send_word(16'hF00F);
        repeat (6) @(negedge dck);
        chk("t4_bit7_den", den, 1);
        en = 1'b0;
        repeat (40) @(negedge dck);
        chk("t4_first_done", words_done, 261);
        chk("t4_den_held", den, 0);
        chk("t4_ready_low", pix_ready, 0);
        chk("t4_pending", exp_q.size(), 1);
        en = 1'b1;
        @(negedge dck);
        chk("t4_resume_den", den, 1);
        wait_words(262);
        repeat (3) @(negedge dck);

        // Asynchronous reset in the middle of a word
        base = words_done;
        send_word(16'h3C3C);
        repeat (10) @(negedge dck);
        chk("t5_pre_den", den, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_den", den, 0);
        chk("t5_dai", dai, 0);
        chk("t5_word_cnt", word_cnt, 0);
        chk("t5_pix_ready", pix_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge dck);
        rst = 1'b0;
        @(negedge dck);
        chk("t5_no_partial", words_done, base);
        send_word(16'h8001);
        wait_words(base + 1);
        repeat (3) @(negedge dck);
        chk("t5_word_cnt_after", word_cnt, 1);
        chk("t5_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
